// File: rtl/tile_blitter.sv
// Tile blitter: copies a 16x16 tile or a full-screen image from ROM into the VGA
// write port, one pixel per clock, behind a two-stage address/data pipeline.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   go                   : start request, sampled only while idle
//   X, Y                 : destination top-left corner
//   memory_select        : 0=tile 16x16, 1=stage, 2=title, 3=none
//   tile_select          : tile index in tile mode
//   rom_addr, rom_sel    : ROM read address (combinational) and bank select
//   rom_data             : ROM colour, one cycle after rom_addr
//   X_out, Y_out, colour : VGA pixel coordinate and colour
//   write_en             : VGA write strobe
//   busy, finished       : operation in progress, single-cycle done pulse
module tile_blitter #(
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter logic [2:0]  TRANSPARENT = 3'b101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic [8:0]  X,
    input  logic [7:0]  Y,
    input  logic [1:0]  memory_select,
    input  logic [3:0]  tile_select,
    output logic [16:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic [2:0]  rom_data,
    output logic [8:0]  X_out,
    output logic [7:0]  Y_out,
    output logic [2:0]  colour,
    output logic        write_en,
    output logic        busy,
    output logic        finished
);

    localparam int unsigned XW   = 9;
    localparam int unsigned YW   = 8;
    localparam int unsigned AW   = 17;
    localparam int unsigned TILE_DIM = 16;
    localparam int unsigned TILE_N   = TILE_DIM * TILE_DIM;
    localparam int unsigned FULL_N   = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [AW-1:0]  lin, lin_next;
    logic [XW-1:0]  cx, cx_next;
    logic [YW-1:0]  cy, cy_next;
    logic           drain_cnt, drain_next;
    logic           accept;

    // Operands latched on accept
    logic [XW-1:0]  x0;
    logic [YW-1:0]  y0;
    logic [1:0]     msel;
    logic [3:0]     tsel;

    // First pipeline stage: coordinates travelling alongside the ROM read
    logic           v1;
    logic [XW-1:0]  cx1;
    logic [YW-1:0]  cy1;

    logic           tile_mode;
    logic [XW-1:0]  width_m1;
    logic [AW-1:0]  last_lin;
    logic [AW-1:0]  base;
    logic           addr_valid;
    logic [XW:0]    sum_x;
    logic [YW:0]    sum_y;
    logic           on_screen;
    logic           opaque;

    assign tile_mode = (msel == 2'd0);
    assign width_m1  = tile_mode ? XW'(TILE_DIM - 1) : XW'(SCREEN_W - 1);
    assign last_lin  = tile_mode ? AW'(TILE_N - 1) : AW'(FULL_N - 1);
    assign base      = tile_mode ? AW'({tsel, 8'h00}) : '0;
    assign rom_addr  = base + lin;
    assign rom_sel   = msel;

    // The last address is still presented during the first drain cycle
    assign addr_valid = (state == STREAM) || ((state == DRAIN) && !drain_cnt);

    assign sum_x     = (XW+1)'(x0) + (XW+1)'(cx1);
    assign sum_y     = (YW+1)'(y0) + (YW+1)'(cy1);
    assign on_screen = (sum_x < (XW+1)'(SCREEN_W)) && (sum_y < (YW+1)'(SCREEN_H));
    assign opaque    = !(tile_mode && (rom_data == TRANSPARENT));

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        lin_next   = lin;
        cx_next    = cx;
        cy_next    = cy;
        drain_next = drain_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    accept     = 1'b1;
                    lin_next   = '0;
                    cx_next    = '0;
                    cy_next    = '0;
                    drain_next = 1'b0;
                    state_next = (memory_select == 2'd3) ? DONE : STREAM;
                end
            end
            STREAM: begin
                lin_next = lin + AW'(1);
                if (cx == width_m1) begin
                    cx_next = '0;
                    cy_next = cy + YW'(1);
                end else begin
                    cx_next = cx + XW'(1);
                end
                // Leave once the final address is being presented
                if (lin == last_lin - AW'(1)) begin
                    state_next = DRAIN;
                    drain_next = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_next = DONE;
                end else begin
                    drain_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and latched operands
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lin       <= '0;
            cx        <= '0;
            cy        <= '0;
            drain_cnt <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            msel      <= '0;
            tsel      <= '0;
        end else begin
            state     <= state_next;
            lin       <= lin_next;
            cx        <= cx_next;
            cy        <= cy_next;
            drain_cnt <= drain_next;
            if (accept) begin
                x0   <= X;
                y0   <= Y;
                msel <= memory_select;
                tsel <= tile_select;
            end
        end
    end

    // Pipeline and registered VGA/handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            cx1      <= '0;
            cy1      <= '0;
            X_out    <= '0;
            Y_out    <= '0;
            colour   <= '0;
            write_en <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            v1       <= addr_valid;
            cx1      <= cx;
            cy1      <= cy;
            if (v1) begin
                X_out  <= sum_x[XW-1:0];
                Y_out  <= sum_y[YW-1:0];
                colour <= rom_data;
            end
            write_en <= v1 && on_screen && opaque;
            // busy covers the finished cycle as well
            busy     <= (state_next != IDLE) || (state == DONE);
            finished <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter with a synchronous ROM model and a write monitor.
module tb_tile_blitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [8:0]  X = '0;
    logic [7:0]  Y = '0;
    logic [1:0]  memory_select = '0;
    logic [3:0]  tile_select = '0;
    logic [16:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [2:0]  rom_data = '0;
    logic [8:0]  X_out;
    logic [7:0]  Y_out;
    logic [2:0]  colour;
    logic        write_en;
    logic        busy;
    logic        finished;

    tile_blitter dut (
        .clock(clock), .reset(reset), .go(go), .X(X), .Y(Y),
        .memory_select(memory_select), .tile_select(tile_select),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
        .X_out(X_out), .Y_out(Y_out), .colour(colour), .write_en(write_en),
        .busy(busy), .finished(finished)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Tile content pattern: 0 = all 3'b010, 1 = word 0 transparent, others 3'b111
    int pat = 0;

    function automatic logic [2:0] rom_word(input logic [1:0] sel, input logic [16:0] a);
        if (sel == 2'd0) begin
            if (pat == 0) return 3'b010;
            return (a[7:0] == 8'd0) ? 3'b101 : 3'b111;
        end
        return 3'(a % 17'd8);
    endfunction

    always @(posedge clock) rom_data <= rom_word(rom_sel, rom_addr);

    // Monitor state
    int edge_n = 0;
    int wr_count = 0, fin_count = 0, fin_edge = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int bad_colour = 0, bad_pos = 0, origin_writes = 0;
    int min_addr = 0, max_addr = 0;
    int pix_319_0 = -1, pix_0_1 = -1;
    int cur_x0 = 0, cur_y0 = 0, cur_w = 16, cur_h = 16;
    logic [1:0] cur_sel = '0;
    logic [3:0] cur_tile = '0;

    task automatic clear_stats();
        wr_count = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        bad_colour = 0; bad_pos = 0; origin_writes = 0;
        min_addr = 1 << 20; max_addr = -1; pix_319_0 = -1; pix_0_1 = -1;
    endtask

    task automatic monitor();
        int rx, ry;
        logic [16:0] a;
        forever begin
            @(posedge clock);
            #1;
            edge_n++;
            if (busy) begin
                if (int'(rom_addr) < min_addr) min_addr = int'(rom_addr);
                if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            end
            if (finished) begin
                fin_count++;
                fin_edge = edge_n;
            end
            if (write_en) begin
                if (wr_count == 0) begin
                    first_x = int'(X_out);
                    first_y = int'(Y_out);
                end
                wr_count++;
                last_x = int'(X_out);
                last_y = int'(Y_out);
                rx = int'(X_out) - cur_x0;
                ry = int'(Y_out) - cur_y0;
                if (rx < 0 || rx >= cur_w || ry < 0 || ry >= cur_h || X_out >= 9'd320 || Y_out >= 8'd240)
                    bad_pos++;
                if (cur_sel == 2'd0) a = 17'({cur_tile, 8'h00}) + 17'(ry * 16 + rx);
                else a = 17'(ry * 320 + rx);
                if (colour != rom_word(cur_sel, a)) bad_colour++;
                if (rx == 0 && ry == 0) origin_writes++;
                if (X_out == 9'd319 && Y_out == 8'd0) pix_319_0 = int'(colour);
                if (X_out == 9'd0 && Y_out == 8'd1) pix_0_1 = int'(colour);
            end
        end
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse go for one edge with the given operands; returns the accept edge number
    task automatic start(input int x, input int y, input int sel, input int t, output int e0);
        @(negedge clock);
        X = 9'(x); Y = 8'(y); memory_select = 2'(sel); tile_select = 4'(t);
        cur_x0 = x; cur_y0 = y; cur_sel = 2'(sel); cur_tile = 4'(t);
        cur_w = (sel == 0) ? 16 : 320;
        cur_h = (sel == 0) ? 16 : 240;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        e0 = edge_n;
    endtask

    task automatic wait_fin(input int start_cnt, input int budget);
        int n = 0;
        while (fin_count == start_cnt && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (fin_count == start_cnt) check_eq("finished_timeout", 0, 1);
    endtask

    initial begin
        int e0, fc, wc, f1;
        fork
            monitor();
        join_none
        clear_stats();

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("reset_outputs", int'({rom_sel, X_out, Y_out, colour, write_en, busy, finished}), 0);
        check_eq("reset_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Plain tile copy
        pat = 0; clear_stats(); fc = fin_count;
        start(72, 32, 0, 3, e0);
        check_eq("t1_busy_after_go", int'(busy), 1);
        wait_fin(fc, 400);
        check_eq("t1_writes", wr_count, 256);
        check_eq("t1_first_xy", first_x * 1000 + first_y, 72032);
        check_eq("t1_last_xy", last_x * 1000 + last_y, 87047);
        check_eq("t1_min_addr", min_addr, 768);
        check_eq("t1_max_addr", max_addr, 1023);
        check_eq("t1_colour", bad_colour, 0);
        check_eq("t1_fin_edge", fin_edge - e0, 258);
        check_eq("t1_busy_with_fin", int'(busy), 1);
        @(negedge clock);
        check_eq("t1_busy_low", int'(busy), 0);
        check_eq("t1_fin_single", int'(finished), 0);

        // Transparent origin pixel
        pat = 1; clear_stats(); fc = fin_count;
        start(100, 50, 0, 0, e0);
        wait_fin(fc, 400);
        check_eq("t2_writes", wr_count, 255);
        check_eq("t2_origin_writes", origin_writes, 0);
        check_eq("t2_colour", bad_colour, 0);
        check_eq("t2_fin_edge", fin_edge - e0, 258);

        // Partially off-screen tile
        pat = 0; clear_stats(); fc = fin_count;
        start(312, 232, 0, 1, e0);
        wait_fin(fc, 400);
        check_eq("t3_writes", wr_count, 64);
        check_eq("t3_bad_pos", bad_pos, 0);
        check_eq("t3_last_xy", last_x * 1000 + last_y, 319239);
        check_eq("t3_fin_edge", fin_edge - e0, 258);

        // Full-screen stage image
        clear_stats(); fc = fin_count;
        start(0, 0, 1, 0, e0);
        wait_fin(fc, 80000);
        check_eq("t4_writes", wr_count, 76800);
        check_eq("t4_pix_319_0", pix_319_0, 7);
        check_eq("t4_pix_0_1", pix_0_1, 0);
        check_eq("t4_colour", bad_colour, 0);
        check_eq("t4_fin_edge", fin_edge - e0, 76802);

        // Stray go while busy is ignored
        clear_stats(); fc = fin_count;
        start(40, 40, 0, 2, e0);
        repeat (98) @(negedge clock);
        X = 9'd0; Y = 8'd0; memory_select = 2'd3; tile_select = 4'd9;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        wait_fin(fc, 400);
        repeat (5) @(negedge clock);
        check_eq("t5_writes", wr_count, 256);
        check_eq("t5_bad_pos", bad_pos, 0);
        check_eq("t5_colour", bad_colour, 0);
        check_eq("t5_fin_count", fin_count - fc, 1);
        check_eq("t5_fin_edge", fin_edge - e0, 258);

        // go held high is re-accepted right after DONE
        clear_stats(); fc = fin_count;
        @(negedge clock);
        X = 9'd10; Y = 8'd10; memory_select = 2'd0; tile_select = 4'd1;
        cur_x0 = 10; cur_y0 = 10; cur_sel = 2'd0; cur_tile = 4'd1; cur_w = 16; cur_h = 16;
        go = 1'b1;
        wait_fin(fc, 400);
        f1 = fin_edge;
        @(posedge clock);
        #2 go = 1'b0;
        wait_fin(fc + 1, 400);
        check_eq("t5_rearm_gap", fin_edge - f1, 259);
        check_eq("t5_rearm_writes", wr_count, 512);
        @(negedge clock);
        check_eq("t5_rearm_idle", int'(busy), 0);

        // Reset in the middle of a copy
        clear_stats(); fc = fin_count;
        start(60, 60, 0, 4, e0);
        repeat (49) @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("t6_outputs_zero", int'({X_out, Y_out, colour, write_en, busy, finished}), 0);
        wc = wr_count;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        check_eq("t6_no_finished", fin_count - fc, 0);
        check_eq("t6_no_writes", wr_count - wc, 0);

        // memory_select=3 after reset: finished after E1, no writes
        clear_stats(); fc = fin_count;
        start(5, 5, 3, 0, e0);
        wait_fin(fc, 20);
        check_eq("t7_fin_edge", fin_edge - e0, 1);
        check_eq("t7_writes", wr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
